// File: rtl/imm_pkg.sv
// imm_pkg: shared encodings for the pipelined immediate generator.
// Opcode map and immediate-source codes; CSR uimm gated by IMM_ZICSR_EN.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_NONE = 3'b111
  } imm_src_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_st_t;

  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode -> {imm, src, illegal} for XLEN 32/64.
// IMM_ZICSR_EN splits SYSTEM into CSR-address I-type and zero-extended uimm.
import imm_pkg::*;

module imm_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_src_t        src_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic       legal;
  logic       sys;
  logic       is_i;
  logic       is_s;
  logic       is_b;
  logic       is_j;
  logic       is_u;
  logic       is_z;
  logic       is_none;

  assign opc   = instr_i[6:0];
  assign legal = (instr_i[1:0] == 2'b11);
  assign sys   = legal & (opc == OP_SYSTEM);

  assign is_s = legal & (opc == OP_STORE);
  assign is_b = legal & (opc == OP_BRANCH);
  assign is_j = legal & (opc == OP_JAL);
  assign is_u = legal & ((opc == OP_LUI) | (opc == OP_AUIPC));

`ifdef IMM_ZICSR_EN
  // funct3[2] selects the register-less CSR forms that carry a uimm
  assign is_z = sys & instr_i[14];
  assign is_i = (legal & ((opc == OP_IMM) | (opc == OP_LOAD)
              | (opc == OP_JALR) | (RV64 & (opc == OP_IMM_32))))
              | (sys & ~instr_i[14]);
  assign is_none = legal & ((opc == OP_OP) | (opc == OP_MISC_MEM)
                 | (RV64 & (opc == OP_OP_32)));
`else
  assign is_z = 1'b0;
  assign is_i = legal & ((opc == OP_IMM) | (opc == OP_LOAD)
              | (opc == OP_JALR) | (RV64 & (opc == OP_IMM_32)));
  assign is_none = (legal & ((opc == OP_OP) | (opc == OP_MISC_MEM)
                 | (RV64 & (opc == OP_OP_32)))) | sys;
`endif

  always_comb begin
    imm_o     = '0;
    src_o     = IMM_NONE;
    illegal_o = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm_o = XLEN'($signed(instr_i[31:20]));
        src_o = IMM_I;
      end
      is_s: begin
        imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        src_o = IMM_S;
      end
      is_b: begin
        imm_o = XLEN'($signed({instr_i[31], instr_i[7],
                instr_i[30:25], instr_i[11:8], 1'b0}));
        src_o = IMM_B;
      end
      is_j: begin
        imm_o = XLEN'($signed({instr_i[31], instr_i[19:12],
                instr_i[20], instr_i[30:21], 1'b0}));
        src_o = IMM_J;
      end
      is_u: begin
        imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
        src_o = IMM_U;
      end
      is_z: begin
        imm_o = XLEN'(instr_i[19:15]);
        src_o = IMM_Z;
      end
      is_none: begin
        src_o = IMM_NONE;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind a valid/ready skid buffer (SKID=1)
// or a single register (SKID=0). Define IMM_ZICSR_EN for CSR uimm decode.
import imm_pkg::*;

module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_src,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_src_t        src;
    logic            illegal;
  } word_t;

  localparam word_t WORD_RST = '{
    imm:     '0,
    src:     IMM_NONE,
    illegal: 1'b0
  };

  logic [XLEN-1:0] dec_imm;
  imm_src_t        dec_src;
  logic            dec_ill;
  word_t           dec_w;
  word_t           out_w;

  imm_decode #(
    .XLEN (XLEN)
  ) u_dec (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .src_o     (dec_src),
    .illegal_o (dec_ill)
  );

  assign dec_w = '{imm: dec_imm, src: dec_src, illegal: dec_ill};

  if (SKID != 0) begin : g_skid
    skid_st_t state_q;
    skid_st_t state_d;
    word_t    main_q;
    word_t    main_d;
    word_t    skid_q;
    word_t    skid_d;
    logic     rdy_q;
    logic     acc;

    assign acc = in_valid & rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        main_q  <= WORD_RST;
        skid_q  <= WORD_RST;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != ST_FULL);
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = dec_w;
          end
        end
        ST_ONE: begin
          if (acc && out_ready) begin
            main_d = dec_w;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = dec_w;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain can happen
          if (out_ready) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = rdy_q;
      out_w     = main_q;
    end
  end else begin : g_reg
    logic  valid_q;
    logic  valid_d;
    word_t main_q;
    word_t main_d;
    logic  acc;

    assign acc = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        main_q  <= WORD_RST;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    always_comb begin
      valid_d = acc | (valid_q & ~out_ready);
      main_d  = acc ? dec_w : main_q;
    end

    always_comb begin
      in_ready  = ~valid_q | out_ready;
      out_valid = valid_q;
      out_w     = main_q;
    end
  end

  assign out_imm     = out_w.imm;
  assign out_imm_src = out_w.src;
  assign out_illegal = out_w.illegal;

endmodule
